// File: rtl/gpio_parity_monitor.sv
// Parity checker for the 17-bit GPIO return word with error counting and link-health FSM.
// Optional first-bad-word capture is enabled with `define GPIO_PARITY_MONITOR_CAPTURE_EN.
module gpio_parity_monitor #(
    parameter bit ODD_PARITY   = 1'b0,
    parameter int FAULT_THRESH = 3,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [16:0]      GPIOIN_i,
    input  logic             sample_i,
    input  logic             clear_i,
    output logic [15:0]      data_o,
    output logic             data_valid_o,
    output logic             parity_err_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [1:0]       state_o,
    output logic             fault_o
`ifdef GPIO_PARITY_MONITOR_CAPTURE_EN
    ,
    output logic [16:0]      first_bad_o,
    output logic [15:0]      first_bad_idx_o
`endif
);

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_DEGRADED = 2'b01;
    localparam logic [1:0] ST_FAULT    = 2'b10;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [7:0]       CONSEC_MAX = 8'hFF;
    localparam logic [7:0]       THRESH     = 8'(FAULT_THRESH);

    logic [7:0] consec;
    logic [7:0] consec_inc;
    logic       bad;
    logic       take;
    logic [1:0] state_next;

    assign bad        = GPIOIN_i[16] != (^GPIOIN_i[15:0] ^ ODD_PARITY);
    assign take       = sample_i && !clear_i;
    assign consec_inc = (consec == CONSEC_MAX) ? consec : consec + 8'd1;
    assign fault_o    = (state_o == ST_FAULT);

    // NOTE: state_next gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state_o;
        if (clear_i) begin
            state_next = ST_OK;
        end else if (sample_i) begin
            case (state_o)
                ST_OK: begin
                    if (bad) state_next = (consec_inc >= THRESH) ? ST_FAULT : ST_DEGRADED;
                end
                ST_DEGRADED: begin
                    if (!bad)                      state_next = ST_OK;
                    else if (consec_inc >= THRESH) state_next = ST_FAULT;
                end
                ST_FAULT: state_next = ST_FAULT;
                default:  state_next = ST_OK;
            endcase
        end
    end

    // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_o       <= '0;
            data_valid_o <= 1'b0;
            parity_err_o <= 1'b0;
            err_count_o  <= '0;
            consec       <= '0;
            state_o      <= ST_OK;
        end else begin
            data_valid_o <= sample_i;
            parity_err_o <= take && bad;
            state_o      <= state_next;
            if (sample_i) data_o <= GPIOIN_i[15:0];

            if (clear_i) begin
                err_count_o <= '0;
                consec      <= '0;
            end else if (sample_i) begin
                if (bad) begin
                    if (err_count_o != CNT_MAX) err_count_o <= err_count_o + 1'b1;
                    consec <= consec_inc;
                end else begin
                    consec <= '0;
                end
            end
        end
    end

`ifdef GPIO_PARITY_MONITOR_CAPTURE_EN
    logic [15:0] sample_idx;
    logic        have_first;

    // Index counts every accepted sample; the first bad one is latched until reset/clear.
    always_ff @(posedge clk) begin
        if (reset || (!reset && clear_i)) begin
            first_bad_o     <= '0;
            first_bad_idx_o <= '0;
            sample_idx      <= '0;
            have_first      <= 1'b0;
        end else if (take) begin
            if (sample_idx != 16'hFFFF) sample_idx <= sample_idx + 16'd1;
            if (bad && !have_first) begin
                first_bad_o     <= GPIOIN_i;
                first_bad_idx_o <= sample_idx;
                have_first      <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gpio_parity_monitor.sv
// Bench for gpio_parity_monitor: directed vector table, corner sequences, and random stimulus
// against a behavioural model. Two instances: defaults (even, thresh 3, 8-bit) and (odd, thresh 1, 4-bit).
module tb_gpio_parity_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic [16:0] gpio;
    logic        sample;
    logic        clear;

    logic [15:0] data_a, data_b;
    logic        valid_a, valid_b, perr_a, perr_b, fault_a, fault_b;
    logic [7:0]  cnt_a;
    logic [3:0]  cnt_b;
    logic [1:0]  state_a, state_b;
`ifdef GPIO_PARITY_MONITOR_CAPTURE_EN
    logic [16:0] fb_a, fb_b;
    logic [15:0] fbi_a, fbi_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gpio_parity_monitor dut_a (
        .clk(clk), .reset(reset), .GPIOIN_i(gpio), .sample_i(sample), .clear_i(clear),
        .data_o(data_a), .data_valid_o(valid_a), .parity_err_o(perr_a),
        .err_count_o(cnt_a), .state_o(state_a), .fault_o(fault_a)
`ifdef GPIO_PARITY_MONITOR_CAPTURE_EN
        , .first_bad_o(fb_a), .first_bad_idx_o(fbi_a)
`endif
    );

    gpio_parity_monitor #(.ODD_PARITY(1'b1), .FAULT_THRESH(1), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .GPIOIN_i(gpio), .sample_i(sample), .clear_i(clear),
        .data_o(data_b), .data_valid_o(valid_b), .parity_err_o(perr_b),
        .err_count_o(cnt_b), .state_o(state_b), .fault_o(fault_b)
`ifdef GPIO_PARITY_MONITOR_CAPTURE_EN
        , .first_bad_o(fb_b), .first_bad_idx_o(fbi_b)
`endif
    );

    // Behavioural model: one entry per instance, states as 0=OK 1=DEGRADED 2=FAULT.
    int          p_odd[2]  = '{0, 1};
    int          p_thr[2]  = '{3, 1};
    int          p_cmax[2] = '{255, 15};
    logic [15:0] m_data[2];
    int          m_valid[2], m_perr[2], m_cnt[2], m_consec[2], m_state[2];
    logic [16:0] m_fb[2];
    int          m_fbi[2], m_idx[2], m_have[2];

    task automatic model_step(input logic r, input logic s, input logic c, input logic [16:0] w);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_data[k] = '0; m_valid[k] = 0; m_perr[k] = 0; m_cnt[k] = 0;
                m_consec[k] = 0; m_state[k] = 0;
                m_fb[k] = '0; m_fbi[k] = 0; m_idx[k] = 0; m_have[k] = 0;
            end else begin
                int want;
                bit is_bad;
                want   = ($countones(w[15:0]) % 2) ^ p_odd[k];
                is_bad = (int'(w[16]) != want);
                m_valid[k] = int'(s);
                m_perr[k]  = 0;
                if (s) m_data[k] = w[15:0];
                if (c) begin
                    m_cnt[k] = 0; m_consec[k] = 0; m_state[k] = 0;
                    m_fb[k] = '0; m_fbi[k] = 0; m_idx[k] = 0; m_have[k] = 0;
                end else if (s) begin
                    if (is_bad) begin
                        m_perr[k]   = 1;
                        m_cnt[k]    = (m_cnt[k] < p_cmax[k]) ? m_cnt[k] + 1 : m_cnt[k];
                        m_consec[k] = (m_consec[k] < 255) ? m_consec[k] + 1 : 255;
                        if (m_state[k] != 2) m_state[k] = (m_consec[k] >= p_thr[k]) ? 2 : 1;
                        if (m_have[k] == 0) begin
                            m_have[k] = 1; m_fb[k] = w; m_fbi[k] = m_idx[k];
                        end
                    end else begin
                        m_consec[k] = 0;
                        if (m_state[k] == 1) m_state[k] = 0;
                    end
                    m_idx[k] = (m_idx[k] < 65535) ? m_idx[k] + 1 : 65535;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "/a.data"},  32'(data_a),  32'(m_data[0]));
        check({tag, "/a.valid"}, 32'(valid_a), 32'(m_valid[0]));
        check({tag, "/a.perr"},  32'(perr_a),  32'(m_perr[0]));
        check({tag, "/a.cnt"},   32'(cnt_a),   32'(m_cnt[0]));
        check({tag, "/a.state"}, 32'(state_a), 32'(m_state[0]));
        check({tag, "/a.fault"}, 32'(fault_a), 32'(m_state[0] == 2));
        check({tag, "/b.data"},  32'(data_b),  32'(m_data[1]));
        check({tag, "/b.valid"}, 32'(valid_b), 32'(m_valid[1]));
        check({tag, "/b.perr"},  32'(perr_b),  32'(m_perr[1]));
        check({tag, "/b.cnt"},   32'(cnt_b),   32'(m_cnt[1]));
        check({tag, "/b.state"}, 32'(state_b), 32'(m_state[1]));
        check({tag, "/b.fault"}, 32'(fault_b), 32'(m_state[1] == 2));
`ifdef GPIO_PARITY_MONITOR_CAPTURE_EN
        check({tag, "/a.fb"},  32'(fb_a),  32'(m_fb[0]));
        check({tag, "/a.fbi"}, 32'(fbi_a), 32'(m_fbi[0]));
        check({tag, "/b.fb"},  32'(fb_b),  32'(m_fb[1]));
        check({tag, "/b.fbi"}, 32'(fbi_b), 32'(m_fbi[1]));
`endif
    endtask

    // Inputs change 1 time unit after the edge; outputs are read at that same point.
    task automatic drive(input logic r, input logic s, input logic c, input logic [16:0] w);
        reset = r; sample = s; clear = c; gpio = w;
        @(posedge clk);
        model_step(r, s, c, w);
        #1;
    endtask

    typedef struct {
        logic [16:0] word;
        logic        smp;
        logic        clr;
        logic [15:0] e_data;
        logic        e_valid;
        logic        e_perr;
        logic [7:0]  e_cnt;
        logic [1:0]  e_state;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // Expected values for instance A (even parity, threshold 3, 8-bit counter).
        vecs[0] = '{17'h1_0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 8'd0, 2'b00};
        vecs[1] = '{17'h0_0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1, 8'd1, 2'b01};
        vecs[2] = '{17'h0_0003, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b0, 8'd1, 2'b00};
        vecs[3] = '{17'h0_0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1, 8'd2, 2'b01};
        vecs[4] = '{17'h0_0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1, 8'd3, 2'b01};
        vecs[5] = '{17'h0_0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1, 8'd4, 2'b10};
        vecs[6] = '{17'h1_0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 8'd4, 2'b10};
        vecs[7] = '{17'h0_1234, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 8'd4, 2'b10};
        vecs[8] = '{17'h0_0007, 1'b1, 1'b1, 16'h0007, 1'b1, 1'b0, 8'd0, 2'b00};
        vecs[9] = '{17'h0_0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1, 8'd1, 2'b01};

        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b0, 17'h0_0001);
        check("reset/a.data",  32'(data_a),  32'h0);
        check("reset/a.valid", 32'(valid_a), 32'h0);
        check("reset/a.cnt",   32'(cnt_a),   32'h0);
        check("reset/a.state", 32'(state_a), 32'h0);
        check("reset/a.fault", 32'(fault_a), 32'h0);

        for (int i = 0; i < 10; i++) begin
            drive(1'b0, vecs[i].smp, vecs[i].clr, vecs[i].word);
            check($sformatf("vec%0d/data", i),  32'(data_a),  32'(vecs[i].e_data));
            check($sformatf("vec%0d/valid", i), 32'(valid_a), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d/perr", i),  32'(perr_a),  32'(vecs[i].e_perr));
            check($sformatf("vec%0d/cnt", i),   32'(cnt_a),   32'(vecs[i].e_cnt));
            check($sformatf("vec%0d/state", i), 32'(state_a), 32'(vecs[i].e_state));
            check($sformatf("vec%0d/fault", i), 32'(fault_a), 32'(vecs[i].e_state == 2'b10));
            check_model($sformatf("vec%0d", i));
        end

        // Instance B: 17'h0_0000 is bad under odd parity; threshold 1 faults at once, 4-bit count saturates.
        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b1, 1'b0, 17'h0_0000);
        check("thresh1/b.fault", 32'(fault_b), 32'h1);
        for (int i = 1; i < 20; i++) drive(1'b0, 1'b1, 1'b0, 17'h0_0000);
        check("sat/b.cnt",   32'(cnt_b),   32'd15);
        check("sat/b.state", 32'(state_b), 32'h2);
        check_model("sat");

        // Reset while in FAULT, with a simultaneous sample that must be discarded.
        drive(1'b1, 1'b1, 1'b0, 17'h0_0000);
        check("rst_fault/b.data",  32'(data_b),  32'h0);
        check("rst_fault/b.valid", 32'(valid_b), 32'h0);
        check("rst_fault/b.perr",  32'(perr_b),  32'h0);
        check("rst_fault/b.cnt",   32'(cnt_b),   32'h0);
        check("rst_fault/b.state", 32'(state_b), 32'h0);
        check("rst_fault/b.fault", 32'(fault_b), 32'h0);

        // Capture sequence on B: good, good, bad 0_00A5, bad 0_0000.
        drive(1'b0, 1'b1, 1'b0, 17'h1_0000);
        drive(1'b0, 1'b1, 1'b0, 17'h1_0000);
        drive(1'b0, 1'b1, 1'b0, 17'h0_00A5);
        check("cap/b.perr", 32'(perr_b), 32'h1);
        drive(1'b0, 1'b1, 1'b0, 17'h0_0000);
`ifdef GPIO_PARITY_MONITOR_CAPTURE_EN
        check("cap/b.fb",  32'(fb_b),  32'h0_00A5);
        check("cap/b.fbi", 32'(fbi_b), 32'd2);
`endif
        check_model("cap");

        for (int i = 0; i < 400; i++) begin
            logic        r, s, c;
            logic [16:0] w;
            w = 17'($urandom);
            s = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 19) == 0);
            r = ($urandom_range(0, 49) == 0);
            drive(r, s, c, w);
            check_model($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
